// File: rtl/sitcp_tx_mux.sv
// sitcp_tx_mux: round-robin N-channel byte framer feeding the SiTCP TCP TX port.
// Define SITCP_TX_MUX_CHKSUM_EN to append a mod-256 payload sum after the trailer.
module sitcp_tx_mux #(
    parameter int         N_CH      = 4,
    parameter int         BURST_LEN = 64,
    parameter logic [7:0] HDR_BYTE  = 8'hA5
) (
    input  logic              CLK,
    input  logic              RST,
    input  logic              TCP_OPEN_ACK,
    input  logic              TCP_TX_FULL,
    output logic              TCP_TX_WR,
    output logic [7:0]        TCP_TX_DATA,
    input  logic [N_CH-1:0]   CH_EN,
    input  logic [N_CH-1:0]   CH_VALID,
    input  logic [8*N_CH-1:0] CH_DATA,
    output logic [N_CH-1:0]   CH_READY,
    output logic              BUSY,
    output logic [31:0]       FRAME_CNT
);

    if (N_CH < 1 || N_CH > 16) begin : g_bad_nch
        $error("sitcp_tx_mux: N_CH must be in 1..16");
    end
    if (BURST_LEN < 1 || BURST_LEN > 255) begin : g_bad_burst
        $error("sitcp_tx_mux: BURST_LEN must be in 1..255");
    end

    typedef enum logic [2:0] {
        S_IDLE,
        S_HDR,
        S_CHID,
        S_PAYLOAD,
        S_TRAILER
`ifdef SITCP_TX_MUX_CHKSUM_EN
        , S_CHK
`endif
    } state_t;

    state_t      state_q, state_d;
    logic [3:0]  grant_q, grant_d;
    logic [3:0]  last_q, last_d;
    logic [7:0]  cnt_q, cnt_d;
    logic        wr_q, wr_d;
    logic [7:0]  data_q, data_d;
    logic [31:0] frame_cnt_q, frame_cnt_d;
`ifdef SITCP_TX_MUX_CHKSUM_EN
    logic [7:0]  sum_q, sum_d;
`endif

    logic        found;
    logic [3:0]  pick;
    logic [7:0]  g_byte;
    logic        g_valid;
    logic        pay_rdy;
    logic        done;

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state_q     <= S_IDLE;
            grant_q     <= '0;
            last_q      <= 4'(N_CH - 1);
            cnt_q       <= '0;
            wr_q        <= 1'b0;
            data_q      <= '0;
            frame_cnt_q <= '0;
`ifdef SITCP_TX_MUX_CHKSUM_EN
            sum_q       <= '0;
`endif
        end else begin
            state_q     <= state_d;
            grant_q     <= grant_d;
            last_q      <= last_d;
            cnt_q       <= cnt_d;
            wr_q        <= wr_d;
            data_q      <= data_d;
            frame_cnt_q <= frame_cnt_d;
`ifdef SITCP_TX_MUX_CHKSUM_EN
            sum_q       <= sum_d;
`endif
        end
    end

    // Granted channel's byte/valid, and round-robin search from last_q+1.
    always_comb begin
        g_byte  = '0;
        g_valid = 1'b0;
        found   = 1'b0;
        pick    = grant_q;
        for (int i = 0; i < N_CH; i++) begin
            if (grant_q == 4'(i)) begin
                g_byte  = CH_DATA[8*i +: 8];
                g_valid = CH_VALID[i];
            end
        end
        for (int k = 1; k <= N_CH; k++) begin
            for (int i = 0; i < N_CH; i++) begin
                if (!found && CH_VALID[i] && CH_EN[i] &&
                    i == (int'(last_q) + k) % N_CH) begin
                    found = 1'b1;
                    pick  = 4'(i);
                end
            end
        end
    end

    assign pay_rdy = (state_q == S_PAYLOAD) && !TCP_TX_FULL && TCP_OPEN_ACK;

    always_comb begin
        CH_READY = '0;
        for (int i = 0; i < N_CH; i++) begin
            CH_READY[i] = pay_rdy && (grant_q == 4'(i));
        end
    end

    always_comb begin
        state_d     = state_q;
        grant_d     = grant_q;
        last_d      = last_q;
        cnt_d       = cnt_q;
        wr_d        = 1'b0;
        data_d      = data_q;
        frame_cnt_d = frame_cnt_q;
        done        = 1'b0;
`ifdef SITCP_TX_MUX_CHKSUM_EN
        sum_d       = sum_q;
`endif
        if (!TCP_OPEN_ACK) begin
            state_d = S_IDLE;
            cnt_d   = '0;
        end else begin
            unique case (state_q)
                S_IDLE: begin
                    if (found) begin
                        grant_d = pick;
                        state_d = S_HDR;
                    end
                end
                S_HDR: begin
                    if (!TCP_TX_FULL) begin
                        wr_d    = 1'b1;
                        data_d  = HDR_BYTE;
                        cnt_d   = '0;
`ifdef SITCP_TX_MUX_CHKSUM_EN
                        sum_d   = '0;
`endif
                        state_d = S_CHID;
                    end
                end
                S_CHID: begin
                    if (!TCP_TX_FULL) begin
                        wr_d    = 1'b1;
                        data_d  = {4'h0, grant_q};
                        state_d = S_PAYLOAD;
                    end
                end
                S_PAYLOAD: begin
                    if (!TCP_TX_FULL) begin
                        if (g_valid) begin
                            wr_d   = 1'b1;
                            data_d = g_byte;
                            cnt_d  = cnt_q + 8'd1;
`ifdef SITCP_TX_MUX_CHKSUM_EN
                            sum_d  = sum_q + g_byte;
`endif
                            if (cnt_q + 8'd1 == 8'(BURST_LEN)) state_d = S_TRAILER;
                        end else if (cnt_q != 8'd0) begin
                            state_d = S_TRAILER;
                        end
                    end
                end
                S_TRAILER: begin
                    if (!TCP_TX_FULL) begin
                        wr_d   = 1'b1;
                        data_d = cnt_q;
`ifdef SITCP_TX_MUX_CHKSUM_EN
                        state_d = S_CHK;
`else
                        done   = 1'b1;
`endif
                    end
                end
`ifdef SITCP_TX_MUX_CHKSUM_EN
                S_CHK: begin
                    if (!TCP_TX_FULL) begin
                        wr_d   = 1'b1;
                        data_d = sum_q;
                        done   = 1'b1;
                    end
                end
`endif
                default: state_d = S_IDLE;
            endcase
            if (done) begin
                frame_cnt_d = frame_cnt_q + 32'd1;
                last_d      = grant_q;
                cnt_d       = '0;
                state_d     = S_IDLE;
            end
        end
    end

    assign TCP_TX_WR   = wr_q;
    assign TCP_TX_DATA = data_q;
    assign BUSY        = (state_q != S_IDLE);
    assign FRAME_CNT   = frame_cnt_q;

endmodule

// File: tb/tb_sitcp_tx_mux.sv
// tb_sitcp_tx_mux: directed bench for sitcp_tx_mux with per-channel byte sources.
// Frame expectations built from the bench's own source tables.
module tb_sitcp_tx_mux;

    localparam int N_CH = 4;
`ifdef SITCP_TX_MUX_CHKSUM_EN
    localparam int OVH = 4;
`else
    localparam int OVH = 3;
`endif
    localparam int FL = 64 + OVH;

    logic              CLK = 1'b0;
    logic              RST;
    logic              TCP_OPEN_ACK;
    logic              TCP_TX_FULL;
    logic              TCP_TX_WR;
    logic [7:0]        TCP_TX_DATA;
    logic [N_CH-1:0]   CH_EN;
    logic [N_CH-1:0]   CH_VALID;
    logic [8*N_CH-1:0] CH_DATA;
    logic [N_CH-1:0]   CH_READY;
    logic              BUSY;
    logic [31:0]       FRAME_CNT;

    sitcp_tx_mux dut (
        .CLK(CLK), .RST(RST), .TCP_OPEN_ACK(TCP_OPEN_ACK),
        .TCP_TX_FULL(TCP_TX_FULL), .TCP_TX_WR(TCP_TX_WR),
        .TCP_TX_DATA(TCP_TX_DATA), .CH_EN(CH_EN), .CH_VALID(CH_VALID),
        .CH_DATA(CH_DATA), .CH_READY(CH_READY), .BUSY(BUSY),
        .FRAME_CNT(FRAME_CNT)
    );

    always #5 CLK = ~CLK;

    int n_chk  = 0;
    int n_fail = 0;
    int cyc    = 0;
    int base   = 0;
    logic [7:0] txq[$];
    int         txt[$];

    int unsigned src_cnt[N_CH] = '{default: 0};
    int unsigned src_lim[N_CH] = '{default: 0};
    int unsigned src_off[N_CH] = '{default: 0};
    logic [7:0]  mem[N_CH][256];

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Capture every TX byte with its cycle stamp.
    initial forever begin
        @(posedge CLK);
        cyc++;
        #1;
        if (TCP_TX_WR) begin
            txq.push_back(TCP_TX_DATA);
            txt.push_back(cyc);
        end
    end

    always @(posedge CLK)
        for (int i = 0; i < N_CH; i++)
            if (CH_VALID[i] && CH_READY[i]) src_cnt[i] <= src_cnt[i] + 1;

    initial begin
        CH_VALID = '0;
        CH_DATA  = '0;
        forever begin
            @(negedge CLK);
            for (int i = 0; i < N_CH; i++) begin
                CH_VALID[i]       = src_cnt[i] < src_lim[i];
                CH_DATA[8*i +: 8] = mem[i][8'(src_cnt[i] - src_off[i])];
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    task automatic src_set(input int ch, input int n);
        src_off[ch] = src_cnt[ch];
        src_lim[ch] = src_cnt[ch] + n;
    endtask

    task automatic do_reset();
        @(negedge CLK);
        for (int i = 0; i < N_CH; i++) src_lim[i] = src_cnt[i];
        TCP_TX_FULL  = 1'b0;
        TCP_OPEN_ACK = 1'b1;
        CH_EN        = '0;
        RST          = 1'b1;
        @(negedge CLK);
        @(negedge CLK);
        RST  = 1'b0;
        base = txq.size();
    endtask

    task automatic wait_frames(input int n, input int maxc, input string tag);
        int c = 0;
        while (FRAME_CNT < n && c < maxc) begin
            @(negedge CLK);
            c++;
        end
        check(tag, FRAME_CNT >= n, 1);
        @(negedge CLK);
    endtask

    task automatic wait_tx(input int n, input int maxc, input string tag);
        int c = 0;
        while (txq.size() - base < n && c < maxc) begin
            @(negedge CLK);
            c++;
        end
        check(tag, txq.size() - base >= n, 1);
    endtask

    task automatic chk_frame(input int pos, input int ch, input int n,
                             input int kb);
        logic [7:0] e;
        logic [7:0] sum;
        sum = '0;
        check("frame_len", txq.size() >= pos + n + OVH, 1);
        if (txq.size() < pos + n + OVH) return;
        check("hdr", txq[pos], 8'hA5);
        check("chid", txq[pos+1], ch);
        for (int k = 0; k < n; k++) begin
            e = mem[ch][8'(kb + k)];
            sum = sum + e;
            check("payload", txq[pos+2+k], e);
        end
        check("trailer", txq[pos+2+n], n);
`ifdef SITCP_TX_MUX_CHKSUM_EN
        check("chksum", txq[pos+3+n], sum);
`endif
    endtask

    int ord[6] = '{0, 1, 3, 0, 1, 3};
    int rd, wrs, c;

    initial begin
        for (int i = 0; i < N_CH; i++)
            for (int k = 0; k < 256; k++) mem[i][k] = 8'(i * 16 + k);
        RST          = 1'b1;
        TCP_OPEN_ACK = 1'b1;
        TCP_TX_FULL  = 1'b0;
        CH_EN        = '0;
        @(negedge CLK);
        @(negedge CLK);
        check("rst_wr", TCP_TX_WR, 0);
        check("rst_data", TCP_TX_DATA, 0);
        check("rst_ready", CH_READY, 0);
        check("rst_busy", BUSY, 0);
        check("rst_fcnt", FRAME_CNT, 0);
        RST  = 1'b0;
        base = txq.size();

        // ch0 sends 00..09 then drops valid
        CH_EN = 4'b0001;
        src_set(0, 10);
        wait_frames(1, 100, "t1_done");
        check("t1_size", txq.size() - base, 10 + OVH);
        chk_frame(base, 0, 10, 0);
        check("t1_fcnt", FRAME_CNT, 1);
        check("t1_busy", BUSY, 0);

        // ch0 always valid: full bursts with one idle cycle between frames
        do_reset();
        CH_EN = 4'b0001;
        src_set(0, 100000);
        wait_frames(2, 400, "t2_done");
        chk_frame(base, 0, 64, 0);
        chk_frame(base + FL, 0, 64, 64);
        if (txt.size() > base + FL)
            check("t2_gap", txt[base+FL] - txt[base+FL-1], 2);
        check("t2_b2b", txt[base+FL-1-OVH+2] - txt[base+2], 63);

        // round robin with channel 2 masked
        do_reset();
        CH_EN = 4'b1011;
        for (int i = 0; i < N_CH; i++) src_set(i, 100000);
        wait_frames(6, 1000, "t3_done");
        for (int j = 0; j < 6; j++) begin
            if (txq.size() > base + j*FL + 2 + 64) begin
                check("t3_chid", txq[base + j*FL + 1], ord[j]);
                check("t3_trl", txq[base + j*FL + 2 + 64], 8'h40);
            end
        end

        // FULL held 20 cycles in the middle of the payload
        do_reset();
        CH_EN = 4'b0010;
        src_set(1, 30);
        wait_tx(12, 50, "t4_start");
        TCP_TX_FULL = 1'b1;
        rd  = 0;
        wrs = 0;
        repeat (20) begin
            @(negedge CLK);
            if (CH_READY != '0) rd++;
            if (TCP_TX_WR) wrs++;
        end
        TCP_TX_FULL = 1'b0;
        check("t4_ready_full", rd, 0);
        check("t4_wr_full", wrs <= 1, 1);
        wait_frames(1, 200, "t4_done");
        check("t4_size", txq.size() - base, 30 + OVH);
        chk_frame(base, 1, 30, 0);

        // connection drop after 5 payload bytes
        do_reset();
        CH_EN = 4'b0100;
        src_set(2, 100000);
        c = 0;
        while (src_cnt[2] - src_off[2] < 5 && c < 50) begin
            @(negedge CLK);
            c++;
        end
        check("t5_five", src_cnt[2] - src_off[2], 5);
        TCP_OPEN_ACK = 1'b0;
        @(negedge CLK);
        check("t5_wr", TCP_TX_WR, 0);
        check("t5_busy", BUSY, 0);
        check("t5_ready", CH_READY, 0);
        repeat (3) @(negedge CLK);
        check("t5_size", txq.size() - base, 7);
        check("t5_fcnt", FRAME_CNT, 0);
        for (int k = 0; k < 5; k++)
            if (txq.size() > base + 2 + k)
                check("t5_payload", txq[base+2+k], mem[2][k]);
        TCP_OPEN_ACK = 1'b1;
        wait_tx(9, 20, "t5_reopen");
        if (txq.size() >= base + 9) begin
            check("t5_hdr", txq[base+7], 8'hA5);
            check("t5_chid", txq[base+8], 2);
        end

`ifdef SITCP_TX_MUX_CHKSUM_EN
        // checksum: payload FF,02 -> A5,00,FF,02,02,01
        do_reset();
        mem[0][0] = 8'hFF;
        mem[0][1] = 8'h02;
        CH_EN = 4'b0001;
        src_set(0, 2);
        wait_frames(1, 50, "t6_done");
        check("t6_size", txq.size() - base, 6);
        if (txq.size() >= base + 6) begin
            check("t6_b0", txq[base+0], 8'hA5);
            check("t6_b1", txq[base+1], 8'h00);
            check("t6_b2", txq[base+2], 8'hFF);
            check("t6_b3", txq[base+3], 8'h02);
            check("t6_b4", txq[base+4], 8'h02);
            check("t6_b5", txq[base+5], 8'h01);
        end
`endif

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule
